// File: rtl/instruction_encoder_if.sv
// Field-set input channel and encoded-word output channel of the RV32I instruction encoder.
// The master drives instruction fields and consumes encoded words; the slave is the encoder.
interface instruction_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        alt;
    logic [31:0] immediate;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic        out_error;

    modport master (
        output in_valid, opcode, funct3, rd, rs1, rs2, alt, immediate, out_ready,
        input  in_ready, out_valid, instruction, out_error
    );

    modport slave (
        input  in_valid, opcode, funct3, rd, rs1, rs2, alt, immediate, out_ready,
        output in_ready, out_valid, instruction, out_error
    );
endinterface

// File: rtl/instruction_encoder.sv
// Packs decoded RV32I fields into 32-bit instruction words with range checking,
// buffered through a 2-entry output FIFO with handshake counting and a sticky error flag.
module instruction_encoder (
    input  logic                  clk,
    input  logic                  rst_n,
    instruction_encoder_if.slave  bus,
    output logic [15:0]           encoded_count,
    output logic                  sticky_error,
    input  logic                  clear_err
);
    localparam logic [6:0]  LOAD_OP   = 7'b0000011;
    localparam logic [6:0]  STORE_OP  = 7'b0100011;
    localparam logic [6:0]  BRANCH_OP = 7'b1100011;
    localparam logic [6:0]  IMM_OP    = 7'b0010011;
    localparam logic [6:0]  REG_OP    = 7'b0110011;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

    // True when v is the sign extension of its low 12 bits.
    function automatic logic fits_s12(input logic [31:0] v);
        return (&v[31:11]) | ~(|v[31:11]);
    endfunction

    // True when v is the sign extension of its low 13 bits.
    function automatic logic fits_s13(input logic [31:0] v);
        return (&v[31:12]) | ~(|v[31:12]);
    endfunction

    logic [31:0] enc_word_s;
    logic        enc_err_s;
    logic        push_s;
    logic        pop_s;
    logic        in_ready_s;
    logic        out_valid_s;

    logic [31:0] mem_word_r [0:1];
    logic        mem_err_r  [0:1];
    logic        wr_ptr_r;
    logic        rd_ptr_r;
    logic [1:0]  count_r;
    logic        ready_en_r;
    logic [15:0] hs_count_r;
    logic        sticky_r;

    // Format selection and immediate range checking for the presented field set.
    always_comb begin
        enc_word_s = NOP_WORD;
        enc_err_s  = 1'b1;
        case (bus.opcode)
            REG_OP: begin
                enc_word_s = {1'b0, bus.alt, 5'b00000, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
                enc_err_s  = 1'b0;
            end
            IMM_OP: begin
                if (bus.funct3 == 3'b101) begin
                    enc_word_s = {1'b0, bus.alt, 5'b00000, bus.immediate[4:0], bus.rs1, bus.funct3,
                                  bus.rd, bus.opcode};
                    enc_err_s  = |bus.immediate[31:5];
                end else begin
                    enc_word_s = {bus.immediate[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                    enc_err_s  = ~fits_s12(bus.immediate);
                end
            end
            LOAD_OP: begin
                enc_word_s = {bus.immediate[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                enc_err_s  = ~fits_s12(bus.immediate);
            end
            STORE_OP: begin
                enc_word_s = {bus.immediate[11:5], bus.rs2, bus.rs1, bus.funct3, bus.immediate[4:0],
                              bus.opcode};
                enc_err_s  = ~fits_s12(bus.immediate);
            end
            BRANCH_OP: begin
                enc_word_s = {bus.immediate[12], bus.immediate[10:5], bus.rs2, bus.rs1, bus.funct3,
                              bus.immediate[4:1], bus.immediate[11], bus.opcode};
                enc_err_s  = bus.immediate[0] | ~fits_s13(bus.immediate);
            end
            default: begin
                enc_word_s = NOP_WORD;
                enc_err_s  = 1'b1;
            end
        endcase
    end

    // A full FIFO can still accept when its head leaves in the same cycle.
    assign out_valid_s = (count_r != 2'd0);
    assign in_ready_s  = ready_en_r & ((count_r != 2'd2) | bus.out_ready);
    assign push_s      = bus.in_valid & in_ready_s;
    assign pop_s       = out_valid_s & bus.out_ready;

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_s;
    assign bus.instruction = mem_word_r[rd_ptr_r];
    assign bus.out_error   = mem_err_r[rd_ptr_r];
    assign encoded_count   = hs_count_r;
    assign sticky_error    = sticky_r;

    // Input acceptance is held off until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // FIFO storage and pointers; a push into a full FIFO reuses the slot being popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_word_r[i] <= 32'h0000_0000;
                mem_err_r[i]  <= 1'b0;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                mem_word_r[wr_ptr_r] <= enc_word_s;
                mem_err_r[wr_ptr_r]  <= enc_err_s;
                wr_ptr_r             <= ~wr_ptr_r;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Handshake counter (wraps naturally) and sticky error, where a new error beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_count_r <= 16'h0000;
            sticky_r   <= 1'b0;
        end else begin
            if (pop_s) begin
                hs_count_r <= hs_count_r + 16'd1;
            end else begin
                hs_count_r <= hs_count_r;
            end
            if (pop_s && mem_err_r[rd_ptr_r]) begin
                sticky_r <= 1'b1;
            end else if (clear_err) begin
                sticky_r <= 1'b0;
            end else begin
                sticky_r <= sticky_r;
            end
        end
    end
endmodule

// File: tb/tb_instruction_encoder.sv
// Directed and randomized checks of instruction_encoder against an arithmetic reference
// model of the instruction formats and a queue model of the output buffer.
module tb_instruction_encoder;
    logic        clk;
    logic        rst_n;
    logic        clear_err;
    logic [15:0] encoded_count;
    logic        sticky_error;

    instruction_encoder_if bus ();

    instruction_encoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .encoded_count (encoded_count),
        .sticky_error  (sticky_error),
        .clear_err     (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [32:0] exp_q [$];
    logic [15:0] cnt_m     = 16'h0000;
    bit          sticky_m  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Reference encoding from the format rules, using shifts, masks and signed ranges.
    function automatic logic [32:0] ref_encode();
        logic [31:0] imm, w, base;
        int          s;
        bit          e;
        imm  = bus.immediate;
        s    = int'(imm);
        base = (32'(bus.rs1) << 15) | (32'(bus.funct3) << 12) | 32'(bus.opcode);
        case (bus.opcode)
            7'b0110011: begin
                w = base | (32'(bus.alt) << 30) | (32'(bus.rs2) << 20) | (32'(bus.rd) << 7);
                e = 1'b0;
            end
            7'b0010011, 7'b0000011: begin
                if (bus.opcode == 7'b0010011 && bus.funct3 == 3'd5) begin
                    w = base | (32'(bus.alt) << 30) | ((imm % 32'd32) << 20) | (32'(bus.rd) << 7);
                    e = (imm >= 32'd32);
                end else begin
                    w = base | ((imm % 32'd4096) << 20) | (32'(bus.rd) << 7);
                    e = !(s >= -2048 && s <= 2047);
                end
            end
            7'b0100011: begin
                w = base | (((imm / 32'd32) % 32'd128) << 25) | (32'(bus.rs2) << 20)
                         | ((imm % 32'd32) << 7);
                e = !(s >= -2048 && s <= 2047);
            end
            7'b1100011: begin
                w = base | (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                         | (32'(bus.rs2) << 20) | (((imm >> 1) & 32'hF) << 8)
                         | (((imm >> 11) & 32'd1) << 7);
                e = (imm % 32'd2 != 32'd0) || !(s >= -4096 && s <= 4095);
            end
            default: begin
                w = 32'h0000_0013;
                e = 1'b1;
            end
        endcase
        return {e, w};
    endfunction

    task automatic set_fields(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd_v,
                              input logic [4:0] rs1_v, input logic [4:0] rs2_v, input logic alt_v,
                              input logic [31:0] imm_v);
        bus.opcode = op; bus.funct3 = f3; bus.rd = rd_v;
        bus.rs1 = rs1_v; bus.rs2 = rs2_v; bus.alt = alt_v; bus.immediate = imm_v;
    endtask

    task automatic rand_fields();
        logic [6:0] ops [0:4];
        ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0110011};
        bus.opcode = ($urandom_range(0, 5) == 5) ? 7'($urandom) : ops[$urandom_range(0, 4)];
        bus.funct3 = 3'($urandom);
        bus.rd     = 5'($urandom);
        bus.rs1    = 5'($urandom);
        bus.rs2    = 5'($urandom);
        bus.alt    = 1'($urandom);
        case ($urandom_range(0, 3))
            0:       bus.immediate = $urandom;
            1:       bus.immediate = 32'($urandom_range(0, 8191)) - 32'd4096;
            2:       bus.immediate = 32'($urandom_range(0, 63));
            default: bus.immediate = 32'($urandom_range(0, 4095)) - 32'd2048;
        endcase
    endtask

    // One clock: drive, check combinational view, predict handshakes, step, check state.
    task automatic drive_cycle(input bit iv, input bit ordy, input bit clr);
        bit          will_pop, will_push;
        logic [32:0] head;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        clear_err     = clr;
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < 2 || ordy));
        will_pop  = (exp_q.size() != 0) && ordy;
        will_push = iv && (exp_q.size() < 2 || ordy);
        head      = 33'd0;
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            check("head_word", bus.instruction, head[31:0]);
            check("head_err", 32'(bus.out_error), 32'(head[32]));
        end
        if (will_pop) begin
            void'(exp_q.pop_front());
            cnt_m = cnt_m + 16'd1;
        end
        if (will_push) exp_q.push_back(ref_encode());
        @(posedge clk);
        #1;
        if (will_pop && head[32]) sticky_m = 1'b1;
        else if (clr) sticky_m = 1'b0;
        check("encoded_count", 32'(encoded_count), 32'(cnt_m));
        check("sticky_error", 32'(sticky_error), 32'(sticky_m));
    endtask

    // Push one word into an empty FIFO, compare it with a known-good constant, then drain it.
    task automatic known_word(input string tag, input logic [31:0] word, input logic err);
        drive_cycle(1'b1, 1'b0, 1'b0);
        #1;
        check({tag, "_word"}, bus.instruction, word);
        check({tag, "_err"}, 32'(bus.out_error), 32'(err));
        drive_cycle(1'b0, 1'b1, 1'b0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_instruction"}, bus.instruction, 32'h0000_0000);
        check({tag, "_out_error"}, 32'(bus.out_error), 32'd0);
        check({tag, "_count"}, 32'(encoded_count), 32'd0);
        check({tag, "_sticky"}, 32'(sticky_error), 32'd0);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        clear_err = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_fields(7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_edge", 32'(bus.in_ready), 32'd1);

        // Known encodings.
        set_fields(7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 1'b0, 32'd5);
        known_word("addi", 32'h0050_0093, 1'b0);
        set_fields(7'b0110011, 3'b000, 5'd3, 5'd1, 5'd2, 1'b1, 32'd0);
        known_word("sub", 32'h4020_81B3, 1'b0);
        set_fields(7'b0100011, 3'b010, 5'd0, 5'd1, 5'd2, 1'b0, 32'd8);
        known_word("sw", 32'h0020_A423, 1'b0);
        set_fields(7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 1'b0, 32'hFFFF_FFFC);
        known_word("beq", 32'hFE20_8EE3, 1'b0);
        set_fields(7'b0010011, 3'b101, 5'd5, 5'd5, 5'd0, 1'b1, 32'd3);
        known_word("srai", 32'h4032_D293, 1'b0);

        // Error cases and sticky flag.
        set_fields(7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 1'b0, 32'd2048);
        known_word("addi_range", 32'h8000_0093, 1'b1);
        check("sticky_set", 32'(sticky_error), 32'd1);
        drive_cycle(1'b0, 1'b1, 1'b1);
        check("sticky_clear", 32'(sticky_error), 32'd0);
        set_fields(7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 1'b0, 32'd3);
        drive_cycle(1'b1, 1'b0, 1'b0);
        check("beq_odd_err", 32'(bus.out_error), 32'd1);
        drive_cycle(1'b0, 1'b1, 1'b1);
        check("set_beats_clear", 32'(sticky_error), 32'd1);
        set_fields(7'b1111111, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
        known_word("bad_opcode", 32'h0000_0013, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b1);

        // Backpressure: three offers with the output stalled, then release.
        set_fields(7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 1'b0, 32'd1);
        drive_cycle(1'b1, 1'b0, 1'b0);
        set_fields(7'b0010011, 3'b000, 5'd2, 5'd0, 5'd0, 1'b0, 32'd2);
        drive_cycle(1'b1, 1'b0, 1'b0);
        set_fields(7'b0010011, 3'b000, 5'd3, 5'd0, 5'd0, 1'b0, 32'd3);
        drive_cycle(1'b1, 1'b0, 1'b0);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        drive_cycle(1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0);
        check("burst_count", 32'(encoded_count), 32'(cnt_m));

        // Randomized traffic with random stalls and clears.
        for (int i = 0; i < 2000; i++) begin
            rand_fields();
            drive_cycle(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) != 0),
                        bit'($urandom_range(0, 7) == 0));
        end

        // Streaming traffic until the handshake counter wraps.
        guard = 0;
        while (cnt_m != 16'hFFFF && guard < 70000) begin
            rand_fields();
            drive_cycle(1'b1, 1'b1, 1'b0);
            guard++;
        end
        guard = 0;
        while (cnt_m != 16'h0000 && guard < 4) begin
            rand_fields();
            drive_cycle(1'b1, 1'b1, 1'b0);
            guard++;
        end
        check("count_wrap", 32'(encoded_count), 32'h0000_0000);

        // Reset while the FIFO is full.
        drive_cycle(1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0);
        check("full_before_reset", 32'(exp_q.size()), 32'd2);
        rst_n = 1'b0;
        #1;
        reset_checks("midreset");
        exp_q.delete();
        cnt_m = 16'h0000;
        sticky_m = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_cycle(1'b0, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0);
        set_fields(7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 1'b0, 32'd5);
        known_word("post_reset", 32'h0050_0093, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
